decoder_xpt_sequencer: RTL and testbench
========================================

Name: decoder_xpt_sequencer

Overview:
- Parametrised execution-phase (XPT) sequencer for the opcode decoder tree.
- Latches the fetched opcode (Source/notSource) and steps a phase counter through the instruction's execution phases.
- Publishes XPT, notXPT and one-hot decodedXPT to the per-group decoders.
- Handles end-of-instruction (PR_Reset_XPT), prefix carry-over (XIX/XIY/XOTR), next-fetch mode (CM1/CMR) and phase overrun detection.

Parameters:
- XPT_WIDTH, 5, width of the phase counter.
- PHASES, 16, number of legal phases; decodedXPT width; must be ≤ 2^XPT_WIDTH and ≥ 2.
- OVERRUN_HALT, 1, 1 = overrun forces IDLE; 0 = overrun only flags and the counter saturates at PHASES-1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; highest priority.
- op_start  in  1  opcode fetch complete; Source_in valid this cycle.
- Source_in  in  8  fetched opcode byte.
- step  in  1  current phase's bus/ALU action done; advance request.
- wait_n  in  1  0 = stall; step is ignored while low.
- PR_Reset_XPT  in  1  decoder request: current phase is the last one.
- P2_Set_XIX / P2_Set_XIY / P2_Set_XOTR  in  1 each  prefix request, sampled with PR_Reset_XPT.
- P2_Set_CM1 / P2_Set_CMR  in  1 each  next-fetch mode request.
- Source  out  8  latched opcode.
- notSource  out  8  bitwise inverse of Source.
- XPT  out  XPT_WIDTH  current phase.
- notXPT  out  XPT_WIDTH  bitwise inverse of XPT.
- decodedXPT  out  PHASES  one-hot of XPT; all-zero when not in EXEC.
- busy  out  1  high in EXEC.
- prefix  out  3  {XOTR, XIY, XIX} active for the current instruction.
- fetch_cmr  out  1  1 = next fetch is a CMR cycle; 0 = CM1.
- overrun  out  1  sticky error flag.

Behaviour:
- All outputs are registered. notSource and notXPT are always the exact inverses of Source and XPT, including during reset.
- Reset values: state IDLE, Source=0, notSource=8'hFF, XPT=0, notXPT=all ones, decodedXPT=0, busy=0, prefix=0, fetch_cmr=0, overrun=0.
- States: IDLE, EXEC, PREFIXED.
- IDLE:
  - op_start: Source←Source_in, XPT←0, decodedXPT←1, busy←1, go to EXEC; prefix←0.
  - Other inputs are ignored.
- EXEC, when step=1 and wait_n=1 (an "advance"):
  - With PR_Reset_XPT=1 and any P2_Set_X* =1: prefix←those bits (priority XIX > XIY > XOTR; exactly one bit is set), decodedXPT←0, busy←0, go to PREFIXED.
  - With PR_Reset_XPT=1 and no prefix request: prefix←0, decodedXPT←0, busy←0, go to IDLE.
  - With PR_Reset_XPT=0 and XPT < PHASES-1: XPT←XPT+1, decodedXPT shifts left by one.
  - With PR_Reset_XPT=0 and XPT = PHASES-1: overrun←1. If OVERRUN_HALT=1, go to IDLE with prefix←0 and decodedXPT←0. If OVERRUN_HALT=0, hold XPT at PHASES-1.
- EXEC, no advance (step=0 or wait_n=0): all state holds. PR_Reset_XPT and P2_Set_X* are ignored.
- EXEC with op_start=1: protocol error; overrun←1; op_start is otherwise ignored.
- PREFIXED:
  - op_start: same as from IDLE, except prefix is retained for the new instruction.
  - Prefix bits stay set until that instruction ends without a prefix request.
- Fetch mode: P2_Set_CM1 clears fetch_cmr; P2_Set_CMR sets it. Both are sampled in any state. If both are high in the same cycle, CM1 wins and fetch_cmr←0.
- overrun clears only on reset.
- reset during EXEC or PREFIXED returns everything to the reset values on the next edge, regardless of other inputs.
- Counter arithmetic is unsigned XPT_WIDTH-bit. XPT never exceeds PHASES-1 and never wraps.

Test Plan:
- Reset, then op_start with Source_in=8'hC5, four advances with PR_Reset_XPT asserted on the 4th → XPT sequence 0,1,2,3; decodedXPT 0001,0010,0100,1000; then IDLE with busy=0, decodedXPT=0, notSource=8'h3A.
- op_start with Source_in=8'hDD, one advance with PR_Reset_XPT=1 and P2_Set_XIX=1 → PREFIXED, prefix=3'b001. Next op_start with 8'hE5 → EXEC with prefix=001 and XPT=0. End without a prefix request → prefix=0.
- In EXEC at XPT=2, hold wait_n=0 with step=1 for 5 cycles → XPT stays 2. Release wait_n → XPT=3.
- PHASES=4, OVERRUN_HALT=1: four advances with no PR_Reset_XPT → overrun=1, IDLE, XPT=0. Repeat with OVERRUN_HALT=0 → XPT stays at 3, busy=1.
- P2_Set_CMR pulse → fetch_cmr=1. Assert P2_Set_CMR and P2_Set_CM1 together → fetch_cmr=0.
- Reset asserted at XPT=3 in a prefixed EXEC → next cycle all outputs at reset values, including prefix=0 and overrun=0.

Source files
------------

// File: rtl/decoder_xpt_sequencer.sv
// Execution-phase sequencer: latches the fetched opcode and steps a phase
// counter, publishing XPT, its inverse and a one-hot phase vector to the decoders.
module decoder_xpt_sequencer #(
  parameter int XPT_WIDTH    = 5,
  parameter int PHASES       = 16,  // legal range: 2 .. 2**XPT_WIDTH
  parameter bit OVERRUN_HALT = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 op_start,
  input  logic [7:0]           Source_in,
  input  logic                 step,
  input  logic                 wait_n,
  input  logic                 PR_Reset_XPT,
  input  logic                 P2_Set_XIX,
  input  logic                 P2_Set_XIY,
  input  logic                 P2_Set_XOTR,
  input  logic                 P2_Set_CM1,
  input  logic                 P2_Set_CMR,
  output logic [7:0]           Source,
  output logic [7:0]           notSource,
  output logic [XPT_WIDTH-1:0] XPT,
  output logic [XPT_WIDTH-1:0] notXPT,
  output logic [PHASES-1:0]    decodedXPT,
  output logic                 busy,
  output logic [2:0]           prefix,
  output logic                 fetch_cmr,
  output logic                 overrun,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_PREFIXED = 2'd2
  } state_t;

  localparam logic [XPT_WIDTH-1:0] LAST_XPT = XPT_WIDTH'(PHASES - 1);

  state_t                 state_q, state_d;
  logic [7:0]             source_q, source_d;
  logic [7:0]             not_source_q;
  logic [XPT_WIDTH-1:0]   xpt_q, xpt_d;
  logic [XPT_WIDTH-1:0]   not_xpt_q;
  logic [PHASES-1:0]      dec_q, dec_d;
  logic                   busy_q, busy_d;
  logic [2:0]             prefix_q, prefix_d;
  logic                   cmr_q, cmr_d;
  logic                   ovr_q, ovr_d;
  logic                   advance;
  logic                   prefix_req;

  assign advance    = step & wait_n;
  assign prefix_req = P2_Set_XIX | P2_Set_XIY | P2_Set_XOTR;

  always_comb begin
    state_d  = state_q;
    source_d = source_q;
    xpt_d    = xpt_q;
    prefix_d = prefix_q;
    cmr_d    = cmr_q;
    ovr_d    = ovr_q;

    case (state_q)
      ST_IDLE, ST_PREFIXED: begin
        if (op_start) begin
          source_d = Source_in;
          xpt_d    = '0;
          state_d  = ST_EXEC;
          // A prefix carries over only into the instruction it prefixes
          if (state_q == ST_IDLE) prefix_d = 3'b000;
        end
      end
      ST_EXEC: begin
        if (op_start) ovr_d = 1'b1;
        if (advance) begin
          if (PR_Reset_XPT) begin
            xpt_d = '0;
            if (prefix_req) begin
              if (P2_Set_XIX)      prefix_d = 3'b001;
              else if (P2_Set_XIY) prefix_d = 3'b010;
              else                 prefix_d = 3'b100;
              state_d = ST_PREFIXED;
            end else begin
              prefix_d = 3'b000;
              state_d  = ST_IDLE;
            end
          end else if (xpt_q != LAST_XPT) begin
            xpt_d = xpt_q + XPT_WIDTH'(1);
          end else begin
            ovr_d = 1'b1;
            // Without halting, the counter simply saturates on the last phase
            if (OVERRUN_HALT) begin
              xpt_d    = '0;
              prefix_d = 3'b000;
              state_d  = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (P2_Set_CM1)      cmr_d = 1'b0;
    else if (P2_Set_CMR) cmr_d = 1'b1;

    busy_d = (state_d == ST_EXEC);
    dec_d  = '0;
    for (int i = 0; i < PHASES; i++) begin
      dec_d[i] = busy_d && (xpt_d == XPT_WIDTH'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      source_q     <= 8'h00;
      not_source_q <= 8'hFF;
      xpt_q        <= '0;
      not_xpt_q    <= '1;
      dec_q        <= '0;
      busy_q       <= 1'b0;
      prefix_q     <= 3'b000;
      cmr_q        <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      source_q     <= source_d;
      not_source_q <= ~source_d;
      xpt_q        <= xpt_d;
      not_xpt_q    <= ~xpt_d;
      dec_q        <= dec_d;
      busy_q       <= busy_d;
      prefix_q     <= prefix_d;
      cmr_q        <= cmr_d;
      ovr_q        <= ovr_d;
    end
  end

  assign Source     = source_q;
  assign notSource  = not_source_q;
  assign XPT        = xpt_q;
  assign notXPT     = not_xpt_q;
  assign decodedXPT = dec_q;
  assign busy       = busy_q;
  assign prefix     = prefix_q;
  assign fetch_cmr  = cmr_q;
  assign overrun    = ovr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_decoder_xpt_sequencer.sv
// Directed bench: two 4-phase sequencers (halting and saturating) share one
// stimulus stream; outputs are checked 1 ns after each rising edge.
module tb_decoder_xpt_sequencer;

  localparam int XW = 3;
  localparam int PH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          op_start;
  logic [7:0]    Source_in;
  logic          step, wait_n, PR_Reset_XPT;
  logic          P2_Set_XIX, P2_Set_XIY, P2_Set_XOTR, P2_Set_CM1, P2_Set_CMR;

  logic [7:0]    a_source, a_nsource, b_source, b_nsource;
  logic [XW-1:0] a_xpt, a_nxpt, b_xpt, b_nxpt;
  logic [PH-1:0] a_dec, b_dec;
  logic          a_busy, a_cmr, a_ovr, b_busy, b_cmr, b_ovr;
  logic [2:0]    a_prefix, b_prefix;
  logic [1:0]    a_state, b_state;

  int checks = 0;
  int errors = 0;

  decoder_xpt_sequencer #(.XPT_WIDTH(XW), .PHASES(PH), .OVERRUN_HALT(1'b1)) u_halt (
    .clock(clock), .reset(reset), .op_start(op_start), .Source_in(Source_in),
    .step(step), .wait_n(wait_n), .PR_Reset_XPT(PR_Reset_XPT),
    .P2_Set_XIX(P2_Set_XIX), .P2_Set_XIY(P2_Set_XIY), .P2_Set_XOTR(P2_Set_XOTR),
    .P2_Set_CM1(P2_Set_CM1), .P2_Set_CMR(P2_Set_CMR),
    .Source(a_source), .notSource(a_nsource), .XPT(a_xpt), .notXPT(a_nxpt),
    .decodedXPT(a_dec), .busy(a_busy), .prefix(a_prefix), .fetch_cmr(a_cmr),
    .overrun(a_ovr), .dbg_state(a_state)
  );

  decoder_xpt_sequencer #(.XPT_WIDTH(XW), .PHASES(PH), .OVERRUN_HALT(1'b0)) u_sat (
    .clock(clock), .reset(reset), .op_start(op_start), .Source_in(Source_in),
    .step(step), .wait_n(wait_n), .PR_Reset_XPT(PR_Reset_XPT),
    .P2_Set_XIX(P2_Set_XIX), .P2_Set_XIY(P2_Set_XIY), .P2_Set_XOTR(P2_Set_XOTR),
    .P2_Set_CM1(P2_Set_CM1), .P2_Set_CMR(P2_Set_CMR),
    .Source(b_source), .notSource(b_nsource), .XPT(b_xpt), .notXPT(b_nxpt),
    .decodedXPT(b_dec), .busy(b_busy), .prefix(b_prefix), .fetch_cmr(b_cmr),
    .overrun(b_ovr), .dbg_state(b_state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_source"},  32'(a_source),  32'h00);
    chk({tag, "_nsource"}, 32'(a_nsource), 32'hFF);
    chk({tag, "_xpt"},     32'(a_xpt),     32'h0);
    chk({tag, "_nxpt"},    32'(a_nxpt),    32'h7);
    chk({tag, "_dec"},     32'(a_dec),     32'h0);
    chk({tag, "_busy"},    32'(a_busy),    32'h0);
    chk({tag, "_prefix"},  32'(a_prefix),  32'h0);
    chk({tag, "_cmr"},     32'(a_cmr),     32'h0);
    chk({tag, "_ovr"},     32'(a_ovr),     32'h0);
    chk({tag, "_state"},   32'(a_state),   32'h0);
  endtask

  initial begin
    reset = 1'b1; op_start = 1'b0; Source_in = 8'h00; step = 1'b0; wait_n = 1'b1;
    PR_Reset_XPT = 1'b0; P2_Set_XIX = 1'b0; P2_Set_XIY = 1'b0; P2_Set_XOTR = 1'b0;
    P2_Set_CM1 = 1'b0; P2_Set_CMR = 1'b0;

    // Reset state
    tick(); tick();
    chk_reset_values("rst");
    reset = 1'b0;

    // Plain four-phase instruction
    op_start = 1'b1; Source_in = 8'hC5;
    tick();
    op_start = 1'b0;
    chk("p0_source", 32'(a_source), 32'hC5);
    chk("p0_xpt", 32'(a_xpt), 32'd0);
    chk("p0_dec", 32'(a_dec), 32'b0001);
    chk("p0_busy", 32'(a_busy), 32'd1);
    step = 1'b1;
    tick();
    chk("p1_xpt", 32'(a_xpt), 32'd1);
    chk("p1_dec", 32'(a_dec), 32'b0010);
    tick();
    chk("p2_xpt", 32'(a_xpt), 32'd2);
    chk("p2_dec", 32'(a_dec), 32'b0100);
    tick();
    chk("p3_xpt", 32'(a_xpt), 32'd3);
    chk("p3_nxpt", 32'(a_nxpt), 32'b100);
    chk("p3_dec", 32'(a_dec), 32'b1000);
    PR_Reset_XPT = 1'b1;
    tick();
    step = 1'b0; PR_Reset_XPT = 1'b0;
    chk("end_busy", 32'(a_busy), 32'd0);
    chk("end_dec", 32'(a_dec), 32'd0);
    chk("end_nsource", 32'(a_nsource), 32'h3A);
    chk("end_state", 32'(a_state), 32'd0);

    // Ignored inputs in IDLE
    step = 1'b1; PR_Reset_XPT = 1'b1; P2_Set_XIX = 1'b1;
    tick();
    step = 1'b0; PR_Reset_XPT = 1'b0; P2_Set_XIX = 1'b0;
    chk("idle_hold_state", 32'(a_state), 32'd0);
    chk("idle_hold_prefix", 32'(a_prefix), 32'd0);

    // XIX prefix carried into the next instruction
    op_start = 1'b1; Source_in = 8'hDD;
    tick();
    op_start = 1'b0;
    step = 1'b1; PR_Reset_XPT = 1'b1; P2_Set_XIX = 1'b1;
    tick();
    step = 1'b0; PR_Reset_XPT = 1'b0; P2_Set_XIX = 1'b0;
    chk("xix_state", 32'(a_state), 32'd2);
    chk("xix_prefix", 32'(a_prefix), 32'b001);
    chk("xix_busy", 32'(a_busy), 32'd0);
    op_start = 1'b1; Source_in = 8'hE5;
    tick();
    op_start = 1'b0;
    chk("pfx_exec_busy", 32'(a_busy), 32'd1);
    chk("pfx_exec_prefix", 32'(a_prefix), 32'b001);
    chk("pfx_exec_xpt", 32'(a_xpt), 32'd0);
    chk("pfx_exec_source", 32'(a_source), 32'hE5);

    // Stall: wait_n low blocks advances
    step = 1'b1;
    tick(); tick();
    chk("stall_pre_xpt", 32'(a_xpt), 32'd2);
    wait_n = 1'b0;
    repeat (5) tick();
    chk("stall_xpt", 32'(a_xpt), 32'd2);
    chk("stall_dec", 32'(a_dec), 32'b0100);
    wait_n = 1'b1;
    tick();
    chk("release_xpt", 32'(a_xpt), 32'd3);
    PR_Reset_XPT = 1'b1;
    tick();
    step = 1'b0; PR_Reset_XPT = 1'b0;
    chk("pfx_end_prefix", 32'(a_prefix), 32'd0);
    chk("pfx_end_state", 32'(a_state), 32'd0);

    // Fetch mode
    P2_Set_CMR = 1'b1;
    tick();
    P2_Set_CMR = 1'b0;
    chk("cmr_set", 32'(a_cmr), 32'd1);
    tick();
    chk("cmr_hold", 32'(a_cmr), 32'd1);
    P2_Set_CMR = 1'b1; P2_Set_CM1 = 1'b1;
    tick();
    P2_Set_CMR = 1'b0; P2_Set_CM1 = 1'b0;
    chk("cm1_wins", 32'(a_cmr), 32'd0);

    // XIY beats XOTR; op_start in EXEC flags overrun; then reset mid-instruction
    op_start = 1'b1; Source_in = 8'h11;
    tick();
    op_start = 1'b0;
    step = 1'b1; PR_Reset_XPT = 1'b1; P2_Set_XIY = 1'b1; P2_Set_XOTR = 1'b1;
    tick();
    step = 1'b0; PR_Reset_XPT = 1'b0; P2_Set_XIY = 1'b0; P2_Set_XOTR = 1'b0;
    chk("xiy_prio_prefix", 32'(a_prefix), 32'b010);
    op_start = 1'b1; Source_in = 8'h22; P2_Set_CMR = 1'b1;
    tick();
    op_start = 1'b0; P2_Set_CMR = 1'b0;
    step = 1'b1;
    tick(); tick(); tick();
    step = 1'b0;
    chk("rst_pre_xpt", 32'(a_xpt), 32'd3);
    chk("rst_pre_cmr", 32'(a_cmr), 32'd1);
    op_start = 1'b1; Source_in = 8'h99;
    tick();
    op_start = 1'b0;
    chk("proto_ovr", 32'(a_ovr), 32'd1);
    chk("proto_source", 32'(a_source), 32'h22);
    chk("proto_xpt", 32'(a_xpt), 32'd3);
    reset = 1'b1; op_start = 1'b1; step = 1'b1; PR_Reset_XPT = 1'b1; P2_Set_XIX = 1'b1;
    tick();
    reset = 1'b0; op_start = 1'b0; step = 1'b0; PR_Reset_XPT = 1'b0; P2_Set_XIX = 1'b0;
    chk_reset_values("rst_mid");

    // Phase overrun: halting vs saturating instance
    op_start = 1'b1; Source_in = 8'h33;
    tick();
    op_start = 1'b0;
    step = 1'b1;
    tick(); tick(); tick();
    chk("ovr_pre_a_ovr", 32'(a_ovr), 32'd0);
    chk("ovr_pre_b_xpt", 32'(b_xpt), 32'd3);
    tick();
    chk("halt_ovr", 32'(a_ovr), 32'd1);
    chk("halt_state", 32'(a_state), 32'd0);
    chk("halt_xpt", 32'(a_xpt), 32'd0);
    chk("halt_busy", 32'(a_busy), 32'd0);
    chk("halt_dec", 32'(a_dec), 32'd0);
    chk("sat_ovr", 32'(b_ovr), 32'd1);
    chk("sat_xpt", 32'(b_xpt), 32'd3);
    chk("sat_busy", 32'(b_busy), 32'd1);
    chk("sat_dec", 32'(b_dec), 32'b1000);
    tick();
    step = 1'b0;
    chk("sat_hold_xpt", 32'(b_xpt), 32'd3);
    chk("sat_hold_nxpt", 32'(b_nxpt), 32'b100);
    chk("halt_ovr_sticky", 32'(a_ovr), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
